fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Parametrised instruction-fetch stage for the next-generation processor core.
//   Owns the program counter and fetches from the combinational-read instruction memory.
//   Buffers fetched {pc, instruction} pairs in a small prefetch queue drained by decode
//   through a valid/ready handshake. Supports stall (halt) and branch/jump redirect with flush.
// PARAMETERS
//   ADDR_W    32  width of PC and instruction-memory address
//   INST_W    32  instruction width
//   DEPTH     4   prefetch-queue entries; power of two, >= 2
//   RESET_PC  0   PC value loaded at reset
//   PC_STEP   4   PC increment per sequential fetch
// PORTS
//   clk             in   1                  rising-edge clock
//   rst_n           in   1                  reset, synchronous, active-low
//   imem_addr       out  ADDR_W             fetch address (= fetch_pc)
//   imem_req        out  1                  high in cycles where imem_rdata is captured
//   imem_rdata      in   INST_W             instruction at imem_addr, same-cycle (combinational) read
//   halt            in   1                  1 = stop issuing new fetches; queue keeps draining
//   redirect_valid  in   1                  branch/jump taken this cycle
//   redirect_pc     in   ADDR_W             target PC when redirect_valid
//   inst_valid      out  1                  queue head valid
//   inst_data       out  INST_W             queue head instruction
//   inst_pc         out  ADDR_W             queue head PC
//   inst_ready      in   1                  decode accepts head this cycle
//   occupancy       out  $clog2(DEPTH+1)    entries currently held
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): fetch_pc=RESET_PC, rd/wr ptr=0, occupancy=0, storage=0.
//     inst_valid=0, inst_data=0, inst_pc=0. imem_req forced 0 while rst_n=0.
//   - pop  = inst_valid & inst_ready.
//   - push = rst_n & ~halt & ~redirect_valid & (occupancy<DEPTH | pop).
//     Push when full is allowed only with a simultaneous pop.
//   - imem_req = push. imem_addr = fetch_pc always, including during reset (reads RESET_PC).
//   - On push: entry[wr_ptr] <= {fetch_pc, imem_rdata}; wr_ptr++ (wraps mod DEPTH);
//     fetch_pc <= fetch_pc + PC_STEP, mod 2^ADDR_W (wraps silently).
//   - On pop: rd_ptr++ (wraps mod DEPTH).
//   - occupancy: +1 push only, -1 pop only, unchanged on both or neither.
//   - Latency: instruction at PC p enters at the edge ending its fetch cycle.
//     It is visible on inst_* the next cycle (1-cycle fetch-to-decode with an empty queue).
//   - Redirect has priority over everything:
//     -- At the edge: queue flushed (rd_ptr=wr_ptr=0, occupancy=0) and fetch_pc <= redirect_pc.
//     -- No push in the redirect cycle.
//     -- A head accepted by decode in the redirect cycle counts as consumed; no special action.
//     -- First post-redirect instruction is valid 2 cycles after redirect asserts.
//   - Back-to-back redirects: last one wins. redirect during halt still loads PC and flushes.
//   - halt: fetch_pc frozen, no push; pops continue; queue empties to inst_valid=0.
//   - Empty: inst_valid=0; inst_data/inst_pc show storage[rd_ptr] (don't-care to consumers).
//   - Reset mid-operation: full reset state at that edge, in-flight entries discarded.
//   - inst_* driven combinationally from registered storage/rd_ptr; no comb path from inst_ready.
// STRUCTURE
//   - proc_defs.vh (shared include): default ADDR_W/INST_W, RESET_PC, PC_STEP constants.
//   - Sub-module fetch_queue: DEPTH x (ADDR_W+INST_W) sync FIFO.
//     Ports push/pop/flush, wdata/rdata, occupancy; synchronous active-low reset.
//   - fetch_unit: PC register, push/pop/redirect logic, and one fetch_queue instance.
// TESTING (bench: imem model returns inst = 32'hA000_0000 | addr; 10 ns clock)
//   1 Reset 3 cycles, inst_ready=1 -> occupancy=0, inst_valid=0 during reset.
//     First valid: inst_pc=0, inst_data=A000_0000, then pc 4, 8, 12 on consecutive cycles.
//   2 inst_ready=0 from reset -> occupancy 1,2,3,4 then holds 4; imem_req=0 while full.
//     fetch_pc holds 16. Raise inst_ready -> pops pc 0,4,8,12,16 back-to-back,
//     push and pop every cycle, occupancy stays 4.
//   3 Steady stream; redirect_valid=1, redirect_pc=0x100 one cycle -> next cycle occupancy=0.
//     The cycle after, inst_pc=0x100 and inst_data=A000_0100; no stale PC ever appears.
//   4 halt=1 with occupancy=3, inst_ready=1 -> 3 pops, then inst_valid=0, imem_req=0.
//     fetch_pc constant. Release halt -> fetching resumes at the held PC.
//   5 RESET_PC=32'hFFFF_FFF8, ADDR_W=32 -> fetched PCs FFFF_FFF8, FFFF_FFFC, 0000_0000, 4 (wrap).
//   6 Queue full, drive rst_n=0 for one cycle mid-stream -> occupancy=0, inst_valid=0.
//     First post-reset inst_pc=RESET_PC; check DEPTH=2 and DEPTH=8 builds too.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants and the queue-operation encoding used by the
// prefetch queue.
package fetch_unit_pkg;

    localparam int          DEF_ADDR_W   = 32;
    localparam int          DEF_INST_W   = 32;
    localparam int          DEF_DEPTH    = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int          DEF_PC_STEP  = 4;

    typedef enum logic [1:0] {
        Q_HOLD = 2'b00,
        Q_PUSH = 2'b01,
        Q_POP  = 2'b10,
        Q_BOTH = 2'b11
    } q_op_e;

    function automatic q_op_e q_op(input logic push, input logic pop);
        return q_op_e'({pop, push});
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode handshake: fetch presents the queue head, decode accepts it.
interface fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              inst_valid;
    logic [INST_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (output inst_valid, output inst_data, output inst_pc, input inst_ready);
    modport slave  (input inst_valid, input inst_data, input inst_pc, output inst_ready);
endinterface

// File: rtl/fetch_unit_queue.sv
// Synchronous prefetch FIFO holding {pc, instruction} pairs; flush empties it
// in one edge without touching the stored words.
module fetch_unit_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int WIDTH = DEF_ADDR_W + DEF_INST_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [OCC_W-1:0] occupancy_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        occ_d = occ_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            occ_d = '0;
        end else begin
            // Pointers wrap for free because DEPTH is a power of two.
            case (q_op(push_i, pop_i))
                Q_PUSH: begin
                    wr_d  = wr_q + PTR_W'(1);
                    occ_d = occ_q + OCC_W'(1);
                end
                Q_POP: begin
                    rd_d  = rd_q + PTR_W'(1);
                    occ_d = occ_q - OCC_W'(1);
                end
                Q_BOTH: begin
                    wr_d = wr_q + PTR_W'(1);
                    rd_d = rd_q + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            occ_q <= occ_d;
            if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
        end
    end

    assign rdata_o     = mem_q[rd_q];
    assign occupancy_o = occ_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the combinational imem and feeds
// decode through a prefetch queue; redirect flushes, halt freezes fetching.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INST_W   = DEF_INST_W,
    parameter int                DEPTH    = DEF_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int                PC_STEP  = DEF_PC_STEP,
    localparam int               OCC_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_req,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    fetch_unit_if.master      dec,
    output logic [OCC_W-1:0]  occupancy
);

    logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
    logic [ADDR_W+INST_W-1:0] head;
    logic                     pop, push;

    assign pop = dec.inst_valid & dec.inst_ready;
    // A full queue still accepts a fetch when decode frees the head this cycle.
    assign push = rst_n & ~halt & ~redirect_valid &
                  ((occupancy < OCC_W'(DEPTH)) | pop);

    assign imem_addr = fetch_pc_q;
    assign imem_req  = push;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) fetch_pc_d = redirect_pc;
        else if (push)      fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) fetch_pc_q <= RESET_PC;
        else        fetch_pc_q <= fetch_pc_d;
    end

    fetch_unit_queue #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_W + INST_W)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .pop_i       (pop),
        .flush_i     (redirect_valid),
        .wdata_i     ({fetch_pc_q, imem_rdata}),
        .rdata_o     (head),
        .occupancy_o (occupancy)
    );

    assign dec.inst_valid = (occupancy != '0);
    assign dec.inst_pc    = head[ADDR_W+INST_W-1:INST_W];
    assign dec.inst_data  = head[INST_W-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a default DUT under full stimulus, a DEPTH=2
// wrapping-PC build and a DEPTH=8 build sharing clock and reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        halt = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] rpc = '0;
    logic        rdy = 1'b1;
    logic        rdy_8 = 1'b0;

    logic [31:0] addr, rdata, w_addr, w_rdata, e_addr, e_rdata;
    logic        req, w_req, e_req;
    logic [2:0]  occ;
    logic [1:0]  w_occ;
    logic [3:0]  e_occ;

    fetch_unit_if #(.ADDR_W(32), .INST_W(32)) dif ();
    fetch_unit_if #(.ADDR_W(32), .INST_W(32)) wif ();
    fetch_unit_if #(.ADDR_W(32), .INST_W(32)) eif ();

    assign dif.inst_ready = rdy;
    assign wif.inst_ready = 1'b1;
    assign eif.inst_ready = rdy_8;

    assign rdata   = 32'hA000_0000 | addr;
    assign w_rdata = 32'hA000_0000 | w_addr;
    assign e_rdata = 32'hA000_0000 | e_addr;

    fetch_unit u_dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(addr), .imem_req(req), .imem_rdata(rdata),
        .halt(halt), .redirect_valid(redir), .redirect_pc(rpc), .dec(dif), .occupancy(occ)
    );

    fetch_unit #(.DEPTH(2), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst_n(rst_n), .imem_addr(w_addr), .imem_req(w_req), .imem_rdata(w_rdata),
        .halt(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0), .dec(wif), .occupancy(w_occ)
    );

    fetch_unit #(.DEPTH(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .imem_addr(e_addr), .imem_req(e_req), .imem_rdata(e_rdata),
        .halt(1'b0), .redirect_valid(1'b0), .redirect_pc(32'h0), .dec(eif), .occupancy(e_occ)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          known = 0;
    bit          prev_rst = 0;
    logic [63:0] sb[$];
    logic [63:0] sb8[$];
    logic [31:0] exp_pc = '0;
    logic [31:0] exp8 = '0;
    logic [31:0] w_exp = 32'hFFFF_FFF8;
    int          wm = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One clock cycle: compare outputs at the negedge, advance the models, then
    // return just after the posedge so the caller can change inputs.
    task automatic step();
        logic [63:0] e;
        bit pop, push, pop8, push8, popw;
        @(negedge clk);
        pop   = (sb.size() != 0) && rdy;
        push  = rst_n && !halt && !redir && ((sb.size() < 4) || pop);
        pop8  = (sb8.size() != 0) && rdy_8;
        push8 = rst_n && ((sb8.size() < 8) || pop8);
        popw  = (wm != 0);
        if (known) begin
            chk("req", req, push);
            chk("addr", addr, exp_pc);
            chk("occ", occ, sb.size());
            chk("valid", dif.inst_valid, sb.size() != 0);
            if (!prev_rst) begin
                chk("rst_pc", dif.inst_pc, 0);
                chk("rst_data", dif.inst_data, 0);
            end
            if (pop) begin
                e = sb.pop_front();
                chk("pc", dif.inst_pc, e[63:32]);
                chk("data", dif.inst_data, e[31:0]);
            end
            chk("d8_req", e_req, push8);
            chk("d8_occ", e_occ, sb8.size());
            if (pop8) begin
                e = sb8.pop_front();
                chk("d8_pc", eif.inst_pc, e[63:32]);
                chk("d8_data", eif.inst_data, e[31:0]);
            end
            chk("wrap_req", w_req, rst_n);
            chk("wrap_occ", w_occ, wm);
            if (popw) begin
                chk("wrap_pc", wif.inst_pc, w_exp);
                chk("wrap_data", wif.inst_data, 32'hA000_0000 | w_exp);
                w_exp = w_exp + 32'd4;
            end
        end
        if (!rst_n) begin
            sb.delete();
            exp_pc = '0;
        end else if (redir) begin
            sb.delete();
            exp_pc = rpc;
        end else if (push) begin
            sb.push_back({exp_pc, 32'hA000_0000 | exp_pc});
            exp_pc = exp_pc + 32'd4;
        end
        if (!rst_n) begin
            sb8.delete();
            exp8 = '0;
        end else if (push8) begin
            sb8.push_back({exp8, 32'hA000_0000 | exp8});
            exp8 = exp8 + 32'd4;
        end
        if (!rst_n) begin
            wm    = 0;
            w_exp = 32'hFFFF_FFF8;
        end else if (!popw) begin
            wm = wm + 1;
        end
        @(posedge clk);
        #1;
        known    = 1;
        prev_rst = rst_n;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // reset, then free-running stream
        run(3);
        rst_n = 1'b1;
        run(6);
        // fill from reset with decode stalled, then drain at full rate
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        rdy = 1'b0;
        run(7);
        rdy = 1'b1;
        run(6);
        // redirect from a steady stream, then back-to-back redirects
        rdy_8 = 1'b1;
        redir = 1'b1; rpc = 32'h0000_0100;
        run(1);
        redir = 1'b0;
        run(4);
        redir = 1'b1; rpc = 32'h0000_0200;
        run(1);
        rpc = 32'h0000_0300;
        run(1);
        redir = 1'b0;
        rdy = 1'b0;
        run(3);
        // halt with three entries queued; redirect while halted
        halt = 1'b1; rdy = 1'b1;
        run(5);
        redir = 1'b1; rpc = 32'h0000_0040;
        run(1);
        redir = 1'b0;
        run(2);
        halt = 1'b0;
        run(4);
        // fill all queues, then reset mid-stream
        rdy = 1'b0; rdy_8 = 1'b0;
        run(10);
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1; rdy = 1'b1; rdy_8 = 1'b1;
        run(5);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
